// File: rtl/inbox.sv
// inbox: first-word-fall-through byte FIFO that feeds the R register on INBOX.
//
// Parameters
//   DEPTH    entry count, power of two in 2..256
//   AW       pointer width, must equal log2(DEPTH)
// Ports
//   clk      clock, all state updates on its rising edge
//   rst_n    asynchronous active-low reset
//   i_data   write data from the external producer
//   i_wr     push request
//   o_full   FIFO holds DEPTH entries
//   rIn      pop request from the control unit (INBOX instruction)
//   o_empty  FIFO holds no entries
//   o_data   head entry (8'h00 while empty), drives iInbox of R
//   o_count  current occupancy
//   o_ovf    sticky overflow flag
// Build option
//   INBOX_OVF_EN  when defined, o_ovf latches any dropped push until reset;
//                 otherwise o_ovf is tied low.

module inbox #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    i_data,
    input  logic          i_wr,
    output logic          o_full,
    input  logic          rIn,
    output logic          o_empty,
    output logic [7:0]    o_data,
    output logic [AW:0]   o_count,
    output logic          o_ovf
);

    localparam logic [AW:0] FullCount = (AW + 1)'(DEPTH);

    // Storage is intentionally not reset; o_empty masks stale contents.
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [AW:0]   count_next;
    logic          push_ok;
    logic          pop_ok;

    assign o_count = count;
    assign o_full  = (count == FullCount);
    assign o_empty = (count == '0);

    // A pop frees a slot on the same edge, so a full FIFO still accepts a push.
    assign pop_ok  = rIn && !o_empty;
    assign push_ok = i_wr && (!o_full || pop_ok);

    // Head shown combinationally; forced to zero when nothing is queued.
    assign o_data = o_empty ? 8'h00 : mem[rd_ptr];

    always_comb begin
        count_next = count;
        unique case ({push_ok, pop_ok})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // Pointers wrap naturally since DEPTH == 2**AW.
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= i_data;
    end

`ifdef INBOX_OVF_EN
    logic ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (i_wr && !push_ok) begin
            ovf <= 1'b1;
        end
    end

    assign o_ovf = ovf;
`else
    assign o_ovf = 1'b0;
`endif

endmodule
